// File: rtl/movement_sequencer.sv
// movement_sequencer
//   Per-frame scheduler for the movement datapath. Divides vga_clock into
//   movement ticks, then runs the horizontal mover followed by the vertical
//   mover once per tick. The mover owning the current phase gets exclusive
//   use of the single background-tile read port. Each completed pass ends
//   with a one-cycle commit strobe.
//
// Ports
//   vga_clock, reset          : clock, synchronous active-high reset
//   h_start / h_done          : horizontal mover handshake
//   v_start / v_done          : vertical mover handshake
//   h_req, h_row, h_col       : horizontal tile lookup request
//   v_req, v_row, v_col       : vertical tile lookup request
//   h_gnt, v_gnt             : lookup accepted this cycle (combinational)
//   tile_row, tile_col        : address presented to the background array
//   tile_data                 : combinational background read data
//   rsp_valid_h, rsp_valid_v  : lookup response valid (one cycle after grant)
//   rsp_data                  : registered tile code (BDR when out of range)
//   frame_tick                : one-cycle movement tick
//   commit                    : one-cycle pulse, pass complete
//   busy                      : a pass is in progress
//   timeout_err, overrun      : sticky error flags
//   dropped_ticks             : saturating count of ticks dropped while busy
module movement_sequencer #(
  parameter int unsigned TICK_DIVISOR = 416667,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned ROWS         = 12,
  parameter int unsigned COLS         = 17,
  parameter logic [7:0]  BDR          = 8'd0
) (
  input  logic       vga_clock,
  input  logic       reset,
  output logic       h_start,
  input  logic       h_done,
  output logic       v_start,
  input  logic       v_done,
  input  logic       h_req,
  input  logic [3:0] h_row,
  input  logic [4:0] h_col,
  input  logic       v_req,
  input  logic [3:0] v_row,
  input  logic [4:0] v_col,
  output logic       h_gnt,
  output logic       v_gnt,
  output logic [3:0] tile_row,
  output logic [4:0] tile_col,
  input  logic [7:0] tile_data,
  output logic       rsp_valid_h,
  output logic       rsp_valid_v,
  output logic [7:0] rsp_data,
  output logic       frame_tick,
  output logic       commit,
  output logic       busy,
  output logic       timeout_err,
  output logic       overrun,
  output logic [7:0] dropped_ticks
);

  localparam int unsigned TICK_W = (TICK_DIVISOR > 2) ? $clog2(TICK_DIVISOR) : 1;
  localparam int unsigned TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIVISOR - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    H_WAIT = 2'd1,
    V_WAIT = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [TICK_W-1:0] tick_cnt;
  logic [TO_W-1:0]   phase_cnt;
  logic              phase_last;
  logic              h_end, v_end;
  logic              commit_q;
  logic              rsp_valid_h_q, rsp_valid_v_q;
  logic [7:0]        rsp_data_q;
  logic              timeout_q, overrun_q;
  logic [7:0]        dropped_q;
  logic              addr_oob;
  logic              tick_dropped;

  // ---------------------------------------------------------------------
  // Tick divider
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign frame_tick = (tick_cnt == TICK_LAST);

  // ---------------------------------------------------------------------
  // Phase end detection: a done, or the phase counter reaching its limit.
  // Done inputs are only meaningful in their own phase.
  // ---------------------------------------------------------------------
  assign phase_last = (phase_cnt == TO_LAST);
  assign h_end      = (state == H_WAIT) && (h_done || phase_last);
  assign v_end      = (state == V_WAIT) && (v_done || phase_last);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_tick) state_next = H_WAIT;
      H_WAIT:  if (h_end)      state_next = V_WAIT;
      V_WAIT:  if (v_end)      state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. The phase counter is zero only on the first cycle of a
  // phase, so it doubles as the start-pulse qualifier.
  // ---------------------------------------------------------------------
  always_comb begin
    h_start  = 1'b0;
    v_start  = 1'b0;
    h_gnt    = 1'b0;
    v_gnt    = 1'b0;
    tile_row = '0;
    tile_col = '0;
    busy     = (state != IDLE);
    unique case (state)
      H_WAIT: begin
        h_start  = (phase_cnt == '0);
        h_gnt    = h_req;
        tile_row = h_row;
        tile_col = h_col;
      end
      V_WAIT: begin
        v_start  = (phase_cnt == '0);
        v_gnt    = v_req;
        tile_row = v_row;
        tile_col = v_col;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Phase counter: cleared on every state change, counts while in a phase.
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      phase_cnt <= '0;
    end else if (state_next != state) begin
      phase_cnt <= '0;
    end else if (state != IDLE) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Commit strobe: lands on the first IDLE cycle after V_WAIT.
  // ---------------------------------------------------------------------
  always_ff @(posedge vga_clock) begin
    if (reset) begin
      commit_q <= 1'b0;
    end else begin
      commit_q <= v_end;
    end
  end

  assign commit = commit_q;

  // ---------------------------------------------------------------------
  // Tile lookup response. The address mux already follows the owner, so the
  // response is captured from tile_row/tile_col whichever mover was granted.
  // Valid is tied to the grant that was live at the capture edge, so a grant
  // on the last phase cycle still answers after the state moves on.
  // ---------------------------------------------------------------------
  assign addr_oob = (32'(tile_row) >= ROWS) || (32'(tile_col) >= COLS);

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      rsp_valid_h_q <= 1'b0;
      rsp_valid_v_q <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      rsp_valid_h_q <= h_gnt;
      rsp_valid_v_q <= v_gnt;
      if (h_gnt || v_gnt) begin
        rsp_data_q <= addr_oob ? BDR : tile_data;
      end
    end
  end

  assign rsp_valid_h = rsp_valid_h_q;
  assign rsp_valid_v = rsp_valid_v_q;
  assign rsp_data    = rsp_data_q;

  // ---------------------------------------------------------------------
  // Error bookkeeping. A tick seen outside IDLE is discarded, including the
  // cycle on which V_WAIT is being left.
  // ---------------------------------------------------------------------
  assign tick_dropped = frame_tick && (state != IDLE);

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      if (((state == H_WAIT) && !h_done && phase_last) ||
          ((state == V_WAIT) && !v_done && phase_last)) begin
        timeout_q <= 1'b1;
      end
      if (tick_dropped) begin
        overrun_q <= 1'b1;
        if (dropped_q != '1) begin
          dropped_q <= dropped_q + 1'b1;
        end
      end
    end
  end

  assign timeout_err   = timeout_q;
  assign overrun       = overrun_q;
  assign dropped_ticks = dropped_q;

endmodule

// File: tb/tb_movement_sequencer.sv
module tb_movement_sequencer;

  logic       vga_clock = 1'b0;
  logic       reset;
  logic       h_start, v_start;
  logic       h_done, v_done;
  logic       h_req, v_req;
  logic [3:0] h_row, v_row;
  logic [4:0] h_col, v_col;
  logic       h_gnt, v_gnt;
  logic [3:0] tile_row;
  logic [4:0] tile_col;
  logic [7:0] tile_data;
  logic       rsp_valid_h, rsp_valid_v;
  logic [7:0] rsp_data;
  logic       frame_tick, commit, busy, timeout_err, overrun;
  logic [7:0] dropped_ticks;

  int compared = 0;
  int mismatched = 0;

  movement_sequencer #(
    .TICK_DIVISOR(16),
    .TIMEOUT     (8),
    .ROWS        (12),
    .COLS        (17),
    .BDR         (8'd0)
  ) dut (
    .vga_clock    (vga_clock),
    .reset        (reset),
    .h_start      (h_start),
    .h_done       (h_done),
    .v_start      (v_start),
    .v_done       (v_done),
    .h_req        (h_req),
    .h_row        (h_row),
    .h_col        (h_col),
    .v_req        (v_req),
    .v_row        (v_row),
    .v_col        (v_col),
    .h_gnt        (h_gnt),
    .v_gnt        (v_gnt),
    .tile_row     (tile_row),
    .tile_col     (tile_col),
    .tile_data    (tile_data),
    .rsp_valid_h  (rsp_valid_h),
    .rsp_valid_v  (rsp_valid_v),
    .rsp_data     (rsp_data),
    .frame_tick   (frame_tick),
    .commit       (commit),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overrun      (overrun),
    .dropped_ticks(dropped_ticks)
  );

  always #5 vga_clock = ~vga_clock;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hs"},   32'(h_start),       32'd0);
    chk({tag, "_vs"},   32'(v_start),       32'd0);
    chk({tag, "_gnt"},  32'({h_gnt, v_gnt}), 32'd0);
    chk({tag, "_rv"},   32'({rsp_valid_h, rsp_valid_v}), 32'd0);
    chk({tag, "_rd"},   32'(rsp_data),      32'd0);
    chk({tag, "_addr"}, 32'({tile_row, tile_col}), 32'd0);
    chk({tag, "_ft"},   32'(frame_tick),    32'd0);
    chk({tag, "_cm"},   32'(commit),        32'd0);
    chk({tag, "_busy"}, 32'(busy),          32'd0);
    chk({tag, "_to"},   32'(timeout_err),   32'd0);
    chk({tag, "_ov"},   32'(overrun),       32'd0);
    chk({tag, "_drop"}, 32'(dropped_ticks), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    h_done = 1'b0; v_done = 1'b0;
    h_req = 1'b0;  v_req = 1'b0;
    h_row = '0; h_col = '0; v_row = '0; v_col = '0;
    tile_data = 8'h00;

    // Reset state
    run(3);
    chk_all_zero("reset");
    reset = 1'b0;

    // Tick period: count 0 now, tick when count reaches 15
    h_done = 1'b1; v_done = 1'b1;
    run(14);
    chk("tick_before", 32'(frame_tick), 32'd0);
    run(1);                                   // T
    chk("tick_T", 32'(frame_tick), 32'd1);
    chk("idle_busy_T", 32'(busy), 32'd0);
    chk("h_start_T", 32'(h_start), 32'd0);

    // Minimum pass with dones already high
    run(1);                                   // T+1
    chk("h_start_T1", 32'(h_start), 32'd1);
    chk("busy_T1", 32'(busy), 32'd1);
    chk("v_start_T1", 32'(v_start), 32'd0);
    run(1);                                   // T+2
    chk("v_start_T2", 32'(v_start), 32'd1);
    chk("h_start_T2", 32'(h_start), 32'd0);
    chk("busy_T2", 32'(busy), 32'd1);
    run(1);                                   // T+3
    chk("commit_T3", 32'(commit), 32'd1);
    chk("busy_T3", 32'(busy), 32'd0);
    run(1);                                   // T+4
    chk("commit_T4", 32'(commit), 32'd0);
    chk("tick_T4", 32'(frame_tick), 32'd0);

    // Both movers request across a whole pass
    h_done = 1'b0; v_done = 1'b0;
    h_req = 1'b1; v_req = 1'b1;
    h_row = 4'd3; h_col = 5'd5; v_row = 4'd3; v_col = 5'd5;
    tile_data = 8'd2;
    #1;
    chk("idle_gnt", 32'({h_gnt, v_gnt}), 32'd0);
    chk("idle_addr", 32'({tile_row, tile_col}), 32'd0);
    run(12);                                  // T+16
    chk("tick_T16", 32'(frame_tick), 32'd1);
    chk("drop_T16", 32'(dropped_ticks), 32'd0);
    chk("rv_idle", 32'({rsp_valid_h, rsp_valid_v}), 32'd0);
    run(1);                                   // T+17
    chk("h_start_T17", 32'(h_start), 32'd1);
    chk("gnt_T17", 32'({h_gnt, v_gnt}), 32'b10);
    chk("row_T17", 32'(tile_row), 32'd3);
    chk("col_T17", 32'(tile_col), 32'd5);
    chk("rv_T17", 32'({rsp_valid_h, rsp_valid_v}), 32'd0);
    run(1);                                   // T+18
    chk("rv_T18", 32'({rsp_valid_h, rsp_valid_v}), 32'b10);
    chk("rd_T18", 32'(rsp_data), 32'd2);
    h_done = 1'b1; h_row = 4'd12; h_col = 5'd0; tile_data = 8'hAA;
    #1;
    chk("gnt_T18", 32'({h_gnt, v_gnt}), 32'b10);
    run(1);                                   // T+19
    chk("rv_T19", 32'({rsp_valid_h, rsp_valid_v}), 32'b10);
    chk("rd_row_oob", 32'(rsp_data), 32'd0);
    chk("v_start_T19", 32'(v_start), 32'd1);
    chk("gnt_T19", 32'({h_gnt, v_gnt}), 32'b01);
    chk("row_T19", 32'(tile_row), 32'd3);
    h_done = 1'b0; v_row = 4'd0; v_col = 5'd17;
    #1;
    chk("addr_T19b", 32'({tile_row, tile_col}), 32'({4'd0, 5'd17}));
    run(1);                                   // T+20
    chk("rv_T20", 32'({rsp_valid_h, rsp_valid_v}), 32'b01);
    chk("rd_col_oob", 32'(rsp_data), 32'd0);
    chk("cm_T20", 32'(commit), 32'd0);
    v_row = 4'd3; v_col = 5'd5; tile_data = 8'h5C; v_done = 1'b1;
    run(1);                                   // T+21
    chk("rv_T21", 32'({rsp_valid_h, rsp_valid_v}), 32'b01);
    chk("rd_T21", 32'(rsp_data), 32'h5C);
    chk("commit_T21", 32'(commit), 32'd1);
    chk("gnt_T21", 32'({h_gnt, v_gnt}), 32'd0);
    chk("addr_T21", 32'({tile_row, tile_col}), 32'd0);
    chk("to_T21", 32'(timeout_err), 32'd0);
    v_done = 1'b0; h_req = 1'b0; v_req = 1'b0;

    // Timeout on both phases; the pass overruns into the next tick
    run(11);                                  // T+32
    chk("tick_T32", 32'(frame_tick), 32'd1);
    run(1);                                   // T+33
    chk("h_start_T33", 32'(h_start), 32'd1);
    run(7);                                   // T+40
    chk("v_start_T40", 32'(v_start), 32'd0);
    chk("to_T40", 32'(timeout_err), 32'd0);
    chk("busy_T40", 32'(busy), 32'd1);
    run(1);                                   // T+41
    chk("v_start_T41", 32'(v_start), 32'd1);
    chk("to_T41", 32'(timeout_err), 32'd1);
    run(7);                                   // T+48
    chk("tick_T48", 32'(frame_tick), 32'd1);
    chk("busy_T48", 32'(busy), 32'd1);
    chk("cm_T48", 32'(commit), 32'd0);
    chk("ov_T48", 32'(overrun), 32'd0);
    run(1);                                   // T+49
    chk("commit_T49", 32'(commit), 32'd1);
    chk("busy_T49", 32'(busy), 32'd0);
    chk("ov_T49", 32'(overrun), 32'd1);
    chk("drop_T49", 32'(dropped_ticks), 32'd1);
    chk("to_T49", 32'(timeout_err), 32'd1);
    run(32);                                  // T+81
    chk("drop_T81", 32'(dropped_ticks), 32'd2);

    // Saturation of the dropped-tick counter
    run(8200);
    chk("drop_sat", 32'(dropped_ticks), 32'd255);
    run(64);
    chk("drop_hold", 32'(dropped_ticks), 32'd255);

    // Reset in the middle of V_WAIT with a live vertical grant
    for (int i = 0; i < 64 && !v_start; i++) run(1);
    chk("v_start_seen", 32'(v_start), 32'd1);
    run(2);
    v_req = 1'b1;
    reset = 1'b1;
    #1;
    chk("gnt_pre_rst", 32'(v_gnt), 32'd1);
    run(1);
    reset = 1'b0;
    chk_all_zero("midrst");
    v_req = 1'b0;
    run(1);
    chk("cm_post_rst", 32'(commit), 32'd0);
    chk("busy_post_rst", 32'(busy), 32'd0);
    run(13);
    chk("tick_pre_fresh", 32'(frame_tick), 32'd0);
    run(1);
    chk("tick_fresh", 32'(frame_tick), 32'd1);
    run(1);
    chk("h_start_fresh", 32'(h_start), 32'd1);
    chk("busy_fresh", 32'(busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
